// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU control sequencer for one MIPS instruction at a time.
// Optional overflow trap for add/sub/addi enabled by defining ALU_SEQ_OVF_TRAP_EN.
module alu_op_sequencer #(
    parameter logic [5:0] RTYPE_OP = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        zout,
    input  logic        minusign,
    input  logic        overflow,
    output logic [2:0]  gin,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic        pc_src,
    output logic        target_load,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        done,
    output logic        illegal,
    output logic        exc
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BLTZ = 6'h01;

    state_t      state, state_next;
    logic [31:0] instr_reg;
    logic        zout_reg, minusign_reg, overflow_reg;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt;
    logic        is_rtype, is_addi, is_beq, is_bltz, rtype_ok, supported, ovf_class, trap;
    logic [2:0]  rtype_gin;

    assign opcode = instr_reg[31:26];
    assign rt     = instr_reg[20:16];
    assign funct  = instr_reg[5:0];

    // Fields not needed for control decode.
    logic unused_fields;
    assign unused_fields = ^{instr_reg[25:21], instr_reg[15:6]};

    always_comb begin
        rtype_ok  = 1'b1;
        rtype_gin = 3'b000;
        case (funct)
            6'h20:   rtype_gin = 3'b010;
            6'h22:   rtype_gin = 3'b110;
            6'h24:   rtype_gin = 3'b000;
            6'h25:   rtype_gin = 3'b001;
            6'h2A:   rtype_gin = 3'b111;
            6'h00:   rtype_gin = 3'b100;
            default: rtype_ok  = 1'b0;
        endcase
    end

    assign is_rtype  = (opcode == RTYPE_OP);
    assign is_addi   = !is_rtype && (opcode == OP_ADDI);
    assign is_beq    = !is_rtype && (opcode == OP_BEQ);
    assign is_bltz   = !is_rtype && (opcode == OP_BLTZ) && (rt == 5'd0);
    assign supported = (is_rtype && rtype_ok) || is_addi || is_beq || is_bltz;
    assign ovf_class = (is_rtype && (funct == 6'h20 || funct == 6'h22)) || is_addi;

`ifdef ALU_SEQ_OVF_TRAP_EN
    assign trap = ovf_class && overflow_reg;
`else
    logic unused_ovf;
    assign unused_ovf = overflow_reg ^ ovf_class;
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            instr_reg    <= 32'h0;
            zout_reg     <= 1'b0;
            minusign_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid)
                instr_reg <= instr;
            if (state == EXEC) begin
                zout_reg     <= zout;
                minusign_reg <= minusign;
                overflow_reg <= overflow;
            end
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        gin         = 3'b000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        target_load = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        exc         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = FETCH;
            end
            FETCH: begin
                gin        = 3'b010;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                gin         = 3'b010;
                alu_src_b   = 2'b11;
                target_load = 1'b1;
                state_next  = supported ? EXEC : WB;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                state_next = WB;
                if (is_rtype)
                    gin = rtype_gin;
                else if (is_addi) begin
                    gin       = 3'b010;
                    alu_src_b = 2'b10;
                end else if (is_beq)
                    gin = 3'b110;
                else if (is_bltz)
                    gin = 3'b011;
            end
            WB: begin
                done       = 1'b1;
                state_next = IDLE;
                if (!supported)
                    illegal = 1'b1;
                else if (is_rtype || is_addi) begin
                    reg_write = !trap;
                    reg_dst   = is_rtype;
                    exc       = trap;
                end else if (is_beq) begin
                    pc_write = zout_reg;
                    pc_src   = zout_reg;
                end else begin
                    // bltz: ALU sum is stale on 011, so only the sign flag counts.
                    pc_write = minusign_reg;
                    pc_src   = minusign_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
